arbitrated_memory: RTL and testbench

ARBITRATED_MEMORY -- requirements
Module: arbitrated_memory

---
 rtl/arbitrated_memory.sv | 128 ++++++++++++
 tb/tb_arbitrated_memory.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/arbitrated_memory.sv
// Byte-addressed line memory shared by NUM_PORTS requesters.
// Round-robin grant, fixed wait latency, masked line writes.
module arbitrated_memory #(
  parameter int ADDRESS_SIZE     = 12,
  parameter int CACHE_LINE_SIZE  = 128,
  parameter int MEMORY_LOCATIONS = 4096,
  parameter int OP_DELAY_CYCLES  = 3,
  parameter int NUM_PORTS        = 2,
  parameter     PROGRAM          = ""
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [NUM_PORTS-1:0]                  req,
  input  logic [NUM_PORTS-1:0]                  op,
  input  logic [NUM_PORTS*ADDRESS_SIZE-1:0]     address,
  input  logic [NUM_PORTS*CACHE_LINE_SIZE-1:0]  data_in,
  input  logic [NUM_PORTS*CACHE_LINE_SIZE/8-1:0] byte_mask,
  output logic [CACHE_LINE_SIZE-1:0]            data_out,
  output logic [NUM_PORTS-1:0]                  data_ready,
  output logic                                  busy
);

  localparam int LB  = CACHE_LINE_SIZE / 8;
  localparam int PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW  = $clog2(OP_DELAY_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS
  } state_t;

  state_t                     r_state;
  logic [CW-1:0]              r_cnt;
  logic [PW-1:0]              r_last;
  logic                       r_op;
  logic [ADDRESS_SIZE-1:0]    r_addr;
  logic [CACHE_LINE_SIZE-1:0] r_data;
  logic [LB-1:0]              r_mask;
  logic [7:0]                 r_mem [MEMORY_LOCATIONS];

  logic                       w_any;
  logic [PW-1:0]              w_grant;
  logic                       w_op;
  logic [ADDRESS_SIZE-1:0]    w_addr;
  logic [CACHE_LINE_SIZE-1:0] w_data;
  logic [LB-1:0]              w_mask;

  initial begin
    for (int i = 0; i < MEMORY_LOCATIONS; i++)
      r_mem[i] = 8'h00;
  end

  // Lowest offset after the last grant wins; scan from far to near.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    w_op    = 1'b0;
    w_addr  = '0;
    w_data  = '0;
    w_mask  = '0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      if (req[(int'(r_last) + i) % NUM_PORTS]) begin
        w_any   = 1'b1;
        w_grant = PW'((int'(r_last) + i) % NUM_PORTS);
      end
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (PW'(p) == w_grant) begin
        w_op   = op[p];
        w_addr = address[p*ADDRESS_SIZE +: ADDRESS_SIZE];
        w_data = data_in[p*CACHE_LINE_SIZE +: CACHE_LINE_SIZE];
        w_mask = byte_mask[p*LB +: LB];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_last     <= PW'(NUM_PORTS - 1);
      data_ready <= '0;
      data_out   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          data_ready <= '0;
          if (w_any) begin
            r_state <= WAIT;
            r_cnt   <= '0;
            r_last  <= w_grant;
            r_op    <= w_op;
            r_addr  <= w_addr & ~ADDRESS_SIZE'(LB - 1);
            r_data  <= w_data;
            r_mask  <= w_mask;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(OP_DELAY_CYCLES - 1))
            r_state <= ACCESS;
        end
        ACCESS: begin
          if (!r_op) begin
            for (int i = 0; i < LB; i++)
              data_out[8*i +: 8] <= r_mem[r_addr | ADDRESS_SIZE'(i)];
          end
          data_ready <= NUM_PORTS'(1) << r_last;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Storage is never cleared; reset only blocks an in-flight write.
  always_ff @(posedge clk) begin
    if (reset_n && r_state == ACCESS && r_op) begin
      for (int i = 0; i < LB; i++)
        if (r_mask[i])
          r_mem[r_addr | ADDRESS_SIZE'(i)] <= r_data[8*i +: 8];
    end
  end

  assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_arbitrated_memory.sv
// Directed bench for arbitrated_memory with default parameters.
module tb_arbitrated_memory;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [1:0]   req;
  logic [1:0]   op;
  logic [23:0]  address;
  logic [255:0] data_in;
  logic [31:0]  byte_mask;
  logic [127:0] data_out;
  logic [1:0]   data_ready;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [127:0] L1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] L2 = 128'h00112233_44556677_8899AABB_CCDDEEAA;
  localparam logic [127:0] P  = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;

  arbitrated_memory dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .op         (op),
    .address    (address),
    .data_in    (data_in),
    .byte_mask  (byte_mask),
    .data_out   (data_out),
    .data_ready (data_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [127:0] got,
                          input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic setup(input int p, input logic w, input logic [11:0] a,
                       input logic [127:0] d, input logic [15:0] m);
    op[p]               = w;
    address[p*12 +: 12] = a;
    data_in[p*128 +: 128] = d;
    byte_mask[p*16 +: 16] = m;
    req[p]              = 1'b1;
  endtask

  // Single transaction from idle: ready expected 5 edges in, one cycle wide.
  task automatic xfer(input string tag, input int p, input logic w,
                      input logic [11:0] a, input logic [127:0] d,
                      input logic [15:0] m);
    int lat;
    lat = -1;
    setup(p, w, a, d, m);
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (data_ready[p]) begin
        lat = k;
        break;
      end
    end
    req[p] = 1'b0;
    check_eq({tag, "_lat"}, lat, 5);
    tick();
    check_eq({tag, "_pulse"}, data_ready, 0);
  endtask

  int          ev_n;
  int          ev_t [3];
  int          ev_p [3];
  logic [127:0] ev_d [3];
  int          busy_n;
  int          cnt;
  int          t0;
  int          t1;

  initial begin
    reset_n   = 1'b0;
    req       = '0;
    op        = '0;
    address   = '0;
    data_in   = '0;
    byte_mask = '0;
    tick();
    tick();
    check_eq("rst_dout", data_out, 0);
    check_eq("rst_ready", data_ready, 0);
    check_eq("rst_busy", busy, 0);
    reset_n = 1'b1;
    tick();

    xfer("wr_full", 0, 1'b1, 12'h010, L1, 16'hFFFF);
    xfer("rd_p1", 1, 1'b0, 12'h010, '0, 16'h0000);
    check_eq("rd_p1_data", data_out, L1);

    xfer("wr_byte", 0, 1'b1, 12'h010, {16{8'hAA}}, 16'h0001);
    xfer("rd_byte", 0, 1'b0, 12'h010, '0, 16'h0000);
    check_eq("rd_byte_data", data_out, L2);

    xfer("wr_other", 0, 1'b1, 12'h030, P, 16'hFFFF);
    check_eq("dout_hold", data_out, L2);

    xfer("rd_unal", 1, 1'b0, 12'h013, '0, 16'h0000);
    check_eq("rd_unal_data", data_out, L2);

    xfer("wr_020", 0, 1'b1, 12'h020, P, 16'hFFFF);

    setup(0, 1'b1, 12'h020, {128{1'b1}}, 16'hFFFF);
    tick();
    check_eq("abort_busy", busy, 1);
    tick();
    reset_n = 1'b0;
    req     = '0;
    tick();
    reset_n = 1'b1;
    check_eq("abort_ready", data_ready, 0);
    check_eq("abort_busy0", busy, 0);
    check_eq("abort_dout", data_out, 0);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (data_ready != 0) cnt++;
    end
    check_eq("abort_noready", cnt, 0);
    xfer("rd_020", 0, 1'b0, 12'h020, '0, 16'h0000);
    check_eq("rd_020_data", data_out, P);

    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    setup(0, 1'b0, 12'h010, '0, 16'h0000);
    setup(1, 1'b0, 12'h020, '0, 16'h0000);
    ev_n   = 0;
    busy_n = 0;
    for (int t = 1; t <= 15; t++) begin
      tick();
      if (busy) busy_n++;
      if (data_ready != 0 && ev_n < 3) begin
        ev_t[ev_n] = t;
        ev_p[ev_n] = data_ready[1] ? 1 : 0;
        ev_d[ev_n] = data_out;
        ev_n++;
      end
    end
    req = '0;
    tick();
    check_eq("rr_events", ev_n, 3);
    if (ev_n == 3) begin
      check_eq("rr_g0", ev_p[0], 0);
      check_eq("rr_g1", ev_p[1], 1);
      check_eq("rr_g2", ev_p[2], 0);
      check_eq("rr_t0", ev_t[0], 5);
      check_eq("rr_gap1", ev_t[1] - ev_t[0], 5);
      check_eq("rr_gap2", ev_t[2] - ev_t[1], 5);
      check_eq("rr_d0", ev_d[0], L2);
      check_eq("rr_d1", ev_d[1], P);
    end
    check_eq("rr_busy", busy_n, 12);
    tick();

    setup(0, 1'b0, 12'h020, '0, 16'h0000);
    tick();
    tick();
    setup(1, 1'b0, 12'h010, '0, 16'h0000);
    t0 = -1;
    t1 = -1;
    for (int t = 3; t <= 30; t++) begin
      tick();
      if (data_ready[0] && t0 < 0) begin
        t0 = t;
        req[0] = 1'b0;
      end
      if (t == 6) check_eq("late_busy", busy, 1);
      if (data_ready[1]) begin
        t1 = t;
        req[1] = 1'b0;
        break;
      end
    end
    check_eq("late_p0", t0, 5);
    check_eq("late_p1", t1, 10);
    check_eq("late_data", data_out, L2);
    tick();
    check_eq("late_pulse", data_ready, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
